// File: rtl/md_pkg.sv
// Shared op encodings, FSM states and decode predicates for md_sched.
// MADD-family ops are decoded only when MD_MADD_EN is defined.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_t;

  function automatic logic is_mult(input md_op_t op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU)
          || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter; done is high in the enabled cycle where count is 0.
// Ports: clk, rst_n, load, init, en, done.
module md_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] init,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= init;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = en && (cnt == '0);

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mul/div scheduler owning HI/LO; optional MD_MADD_EN adds MADD family.
// Ports: clk, rst_n, start, op, rs_val, rt_val -> busy, hi, lo.
import md_pkg::*;

module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int W    = (MAXC > 1) ? $clog2(MAXC) : 1;

  md_state_t   state;
  md_op_t      op_in;
  md_op_t      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        launch;
  logic        done;
  logic [W-1:0] init;

  assign op_in  = md_op_t'(op);
  assign launch = (state == ST_IDLE) && start
                  && (is_mult(op_in) || is_div(op_in));
  assign init   = is_div(op_in) ? W'(DIV_CYCLES - 1) : W'(MULT_CYCLES - 1);

  md_timer #(.W(W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .init  (init),
    .en    (state == ST_RUN),
    .done  (done)
  );

  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic        [31:0] res_hi;
  logic        [31:0] res_lo;
  logic               wr;

  assign sa     = $signed(a_q);
  assign sb     = $signed(b_q);
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    wr     = 1'b1;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (b_q == 32'd0) begin
          wr = 1'b0;
        end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          // Overflow case: quotient wraps to the dividend, remainder 0.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = 32'(sa / sb);
          res_hi = 32'(sa % sb);
        end
      end
      OP_DIVU: begin
        if (b_q == 32'd0) begin
          wr = 1'b0;
        end else begin
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
`ifdef MD_MADD_EN
      // HI/LO cannot change during RUN, so live {hi,lo} equals its E0 value.
      OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
      OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
      OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
      default:  wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_NOP;
    end else begin
      case (state)
        ST_IDLE: begin
          unique case (1'b1)
            launch: begin
              a_q   <= rs_val;
              b_q   <= rt_val;
              op_q  <= op_in;
              state <= ST_RUN;
              busy  <= 1'b1;
            end
            (start && op_in == OP_MTHI): hi <= rs_val;
            (start && op_in == OP_MTLO): lo <= rs_val;
            default: ;
          endcase
        end
        ST_RUN: begin
          if (done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
